// File: rtl/pmod_ad1_ggwp.sv
// rtl/pmod_ad1_ggwp.sv - dual-channel Pmod AD1 serial ADC master with 12.5 kHz SCLK and CS framing
// Optional ADC_MASK12_EN: clear bits [15:12] of both words when they are loaded.
module pmod_ad1_ggwp #(
  parameter int HALF_DIV  = 4000,
  parameter int QUIET_CYC = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dDATA1,
  input  logic        dDATA2,
  output logic [15:0] DATA1,
  output logic [15:0] DATA2,
  output logic        CS,
  output logic        CLK12_5K,
  output logic [7:0]  led
);

  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int QW = $clog2(QUIET_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_next;
  logic [DW-1:0] div_cnt;
  logic [QW-1:0] quiet_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   sr1, sr2;
  logic          wrap, rise_evt, fall_evt;
  logic          start_frame, shift_en, load_en, quiet_inc;

  // Events are decoded from the value CLK12_5K holds before it toggles.
  assign wrap     = (div_cnt == DW'(HALF_DIV - 1));
  assign rise_evt = wrap && !CLK12_5K;
  assign fall_evt = wrap && CLK12_5K;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt  <= '0;
      CLK12_5K <= 1'b1;
    end else if (wrap) begin
      div_cnt  <= '0;
      CLK12_5K <= ~CLK12_5K;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    load_en     = 1'b0;
    quiet_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (fall_evt) begin
          if (quiet_cnt == QW'(QUIET_CYC - 1)) begin
            start_frame = 1'b1;
            state_next  = SHIFT;
          end else begin
            quiet_inc = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (rise_evt) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd15) state_next = DONE;
        end
      end
      DONE: begin
        if (fall_evt) begin
          load_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      CS        <= 1'b1;
      quiet_cnt <= '0;
      bit_cnt   <= '0;
      sr1       <= '0;
      sr2       <= '0;
      DATA1     <= '0;
      DATA2     <= '0;
    end else begin
      state <= state_next;
      if (quiet_inc) quiet_cnt <= quiet_cnt + QW'(1);
      if (start_frame) begin
        CS      <= 1'b0;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        sr1     <= {sr1[14:0], dDATA1};
        sr2     <= {sr2[14:0], dDATA2};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (load_en) begin
`ifdef ADC_MASK12_EN
        DATA1 <= sr1 & 16'h0FFF;
        DATA2 <= sr2 & 16'h0FFF;
`else
        DATA1 <= sr1;
        DATA2 <= sr2;
`endif
        CS        <= 1'b1;
        quiet_cnt <= '0;
      end
    end
  end

  assign led = DATA1[11:4];

endmodule

// File: tb/tb_pmod_ad1_ggwp.sv
// tb/tb_pmod_ad1_ggwp.sv - directed self-checking bench for pmod_ad1_ggwp (HALF_DIV=2, QUIET_CYC=1)
module tb_pmod_ad1_ggwp;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        dDATA1 = 1'b0;
  logic        dDATA2 = 1'b0;
  logic [15:0] DATA1, DATA2;
  logic        CS, CLK12_5K;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  pmod_ad1_ggwp #(.HALF_DIV(2), .QUIET_CYC(1)) dut (
    .CLK(CLK), .RST(RST), .dDATA1(dDATA1), .dDATA2(dDATA2),
    .DATA1(DATA1), .DATA2(DATA2), .CS(CS), .CLK12_5K(CLK12_5K), .led(led)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one frame MSB-first from the negedge where CS is seen low; stops early at stop_at rises.
  task automatic run_frame(input logic [15:0] p1, input logic [15:0] p2, input int stop_at,
                           output int rises, output int low_cyc, output bit timed_out);
    int guard;
    logic prev;
    guard = 0;
    while (CS !== 1'b0 && guard < 400) begin
      @(negedge CLK);
      guard++;
    end
    rises = 0;
    low_cyc = 0;
    prev = CLK12_5K;
    while (guard < 400) begin
      if (CS !== 1'b0) break;
      if (prev === 1'b0 && CLK12_5K === 1'b1) rises++;
      prev = CLK12_5K;
      if (CLK12_5K === 1'b0 && rises < 16) begin
        dDATA1 = p1[15 - rises];
        dDATA2 = p2[15 - rises];
      end
      low_cyc++;
      if (rises >= stop_at) break;
      @(negedge CLK);
      guard++;
    end
    timed_out = (guard >= 400);
  endtask

  task automatic measure_quiet(output int high_cyc);
    high_cyc = 0;
    while (CS === 1'b1 && high_cyc < 100) begin
      @(negedge CLK);
      high_cyc++;
    end
  endtask

  initial begin
    int  rises, low_cyc, high_cyc;
    bit  to;
    logic [15:0] exp_a, exp_b;

    repeat (3) @(negedge CLK);
    chk("rst_cs", CS, 1);
    chk("rst_sclk", CLK12_5K, 1);
    chk("rst_data1", DATA1, 0);
    chk("rst_data2", DATA2, 0);
    chk("rst_led", led, 0);

    RST = 1'b0;
    @(negedge CLK);
    chk("rel1_sclk", CLK12_5K, 1);
    chk("rel1_cs", CS, 1);
    @(negedge CLK);
    chk("rel2_sclk", CLK12_5K, 0);
    chk("rel2_cs", CS, 0);

    run_frame(16'hFFFF, 16'h0000, 99, rises, low_cyc, to);
    chk("f1_timeout", to, 0);
    chk("f1_rises", rises, 16);
    chk("f1_low_cyc", low_cyc, 64);
    chk("f1_data1", DATA1, 16'hFFFF & 16'h0FFF | `ifdef ADC_MASK12_EN 16'h0000 `else 16'hF000 `endif);
    chk("f1_data2", DATA2, 16'h0000);
    chk("f1_led", led, 8'hFF);
    measure_quiet(high_cyc);
    chk("f1_quiet", high_cyc, 4);

    run_frame(16'h0000, 16'hFFFF, 99, rises, low_cyc, to);
    chk("f2_timeout", to, 0);
    chk("f2_rises", rises, 16);
`ifdef ADC_MASK12_EN
    exp_b = 16'h0FFF;
`else
    exp_b = 16'hFFFF;
`endif
    chk("f2_data1", DATA1, 16'h0000);
    chk("f2_data2", DATA2, exp_b);
    chk("f2_led", led, 8'h00);
    measure_quiet(high_cyc);
    chk("f2_quiet", high_cyc, 4);

    run_frame(16'hA5C3, 16'h3C5A, 99, rises, low_cyc, to);
`ifdef ADC_MASK12_EN
    exp_a = 16'h05C3;
    exp_b = 16'h0C5A;
`else
    exp_a = 16'hA5C3;
    exp_b = 16'h3C5A;
`endif
    chk("f3_timeout", to, 0);
    chk("f3_data1", DATA1, exp_a);
    chk("f3_data2", DATA2, exp_b);
    chk("f3_led", led, 8'h5C);

    run_frame(16'hFFFF, 16'hFFFF, 8, rises, low_cyc, to);
    chk("abort_timeout", to, 0);
    chk("abort_rises", rises, 8);
    chk("abort_cs_low", CS, 0);
    RST = 1'b1;
    #1;
    chk("abort_cs", CS, 1);
    chk("abort_sclk", CLK12_5K, 1);
    chk("abort_data1", DATA1, 0);
    chk("abort_data2", DATA2, 0);
    chk("abort_led", led, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_rel_cs", CS, 1);

    run_frame(16'h0F0F, 16'h1234, 99, rises, low_cyc, to);
`ifdef ADC_MASK12_EN
    exp_b = 16'h0234;
`else
    exp_b = 16'h1234;
`endif
    chk("f4_timeout", to, 0);
    chk("f4_rises", rises, 16);
    chk("f4_data1", DATA1, 16'h0F0F);
    chk("f4_data2", DATA2, exp_b);
    chk("f4_led", led, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
